// File: rtl/instr_seq_mem_if.sv
// Program RAM bus between the instruction sequencer and the 16x8 static RAM.
// Read data is registered in the RAM: it is valid the cycle after the cs/addr cycle.
interface instr_seq_mem_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_cs,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle CPU controller: host program load into RAM, then fetch/decode of
// 1- or 2-byte instructions driving registered ALU and register-file control.
module instr_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic              run,
    input  logic              halt_req,
    instr_seq_mem_if.master   mem,
    output logic [2:0]        alu_op,
    output logic              is_add,
    output logic              is_imm,
    output logic [DATA_W-1:0] imm_val,
    output logic              rf_we,
    output logic [1:0]        rf_dst,
    output logic [1:0]        rf_src2,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [7:0]        instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_FWAIT  = 3'd2;
    localparam logic [2:0] S_IFETCH = 3'd3;
    localparam logic [2:0] S_IWAIT  = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;

    localparam logic [2:0]        OP_HALT = 3'b111;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W-1:0] load_ptr;
    logic              wr_pend;
    logic              halt_op;
    logic              halt_pend;
    logic [4:0]        dec;

    // Returns {alu_op, is_add, writes_register}.
    function automatic logic [4:0] decode_op(input logic [2:0] op);
        case (op)
            3'b000:  return {3'b000, 1'b1, 1'b1};
            3'b001:  return {3'b001, 1'b1, 1'b1};
            3'b010:  return {3'b001, 1'b0, 1'b1};
            3'b011:  return {3'b010, 1'b1, 1'b1};
            3'b100:  return {3'b011, 1'b1, 1'b1};
            3'b101:  return {3'b100, 1'b1, 1'b1};
            default: return {3'b000, 1'b1, 1'b0};
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign dec  = decode_op(mem.mem_rdata[7:5]);
    assign busy = (state != S_IDLE);

    // Strobes are qualified by RESET so an abort never leaves a partial write.
    always_comb begin
        mem.mem_cs    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = pc;
        mem.mem_wdata = '0;
        rf_we         = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_en) begin
                    mem.mem_cs    = 1'b1;
                    mem.mem_we    = 1'b1;
                    mem.mem_addr  = load_ptr;
                    mem.mem_wdata = load_data;
                end
            end
            S_FETCH, S_IFETCH: mem.mem_cs = 1'b1;
            S_EXEC:            rf_we      = wr_pend;
            default: ;
        endcase
        if (!RESET) begin
            mem.mem_cs = 1'b0;
            mem.mem_we = 1'b0;
            rf_we      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            pc          <= '0;
            load_ptr    <= '0;
            instr_count <= '0;
            done        <= 1'b0;
            alu_op      <= '0;
            is_add      <= 1'b0;
            is_imm      <= 1'b0;
            imm_val     <= '0;
            rf_dst      <= '0;
            rf_src2     <= '0;
            wr_pend     <= 1'b0;
            halt_op     <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        load_ptr <= load_ptr + ADDR_ONE;
                        done     <= 1'b0;
                    end else if (run) begin
                        pc          <= '0;
                        instr_count <= '0;
                        done        <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_FWAIT;
                S_FWAIT: begin
                    {alu_op, is_add, wr_pend} <= dec;
                    is_imm  <= mem.mem_rdata[0];
                    rf_dst  <= mem.mem_rdata[4:3];
                    rf_src2 <= mem.mem_rdata[2:1];
                    halt_op <= (mem.mem_rdata[7:5] == OP_HALT);
                    pc      <= pc + ADDR_ONE;
                    state   <= mem.mem_rdata[0] ? S_IFETCH : S_EXEC;
                end
                S_IFETCH: state <= S_IWAIT;
                S_IWAIT: begin
                    imm_val <= mem.mem_rdata;
                    pc      <= pc + ADDR_ONE;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    instr_count <= sat_inc(instr_count);
                    if (halt_op) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (halt_req || halt_pend) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A stop request raised mid-instruction is held until EXEC retires it.
            if (state == S_IDLE || state == S_EXEC)
                halt_pend <= 1'b0;
            else if (halt_req)
                halt_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: RAM device, ISA-level reference model, directed and random runs.
module tb_instr_sequencer;

    logic       CLK;
    logic       RESET;
    logic       load_en;
    logic [7:0] load_data;
    logic       run;
    logic       halt_req;
    logic [2:0] alu_op;
    logic       is_add;
    logic       is_imm;
    logic [7:0] imm_val;
    logic       rf_we;
    logic [1:0] rf_dst;
    logic [1:0] rf_src2;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic [7:0] instr_count;

    instr_seq_mem_if #(.ADDR_W(4), .DATA_W(8)) mem_bus ();

    instr_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .load_en    (load_en),
        .load_data  (load_data),
        .run        (run),
        .halt_req   (halt_req),
        .mem        (mem_bus),
        .alu_op     (alu_op),
        .is_add     (is_add),
        .is_imm     (is_imm),
        .imm_val    (imm_val),
        .rf_we      (rf_we),
        .rf_dst     (rf_dst),
        .rf_src2    (rf_src2),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .instr_count(instr_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // The RAM device itself: synchronous write, registered read.
    logic [7:0] ram [16];
    always @(posedge CLK) begin
        if (mem_bus.mem_cs) begin
            if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
            else                mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [2:0] alu;
        logic       add;
        logic       imm;
        logic [7:0] immv;
        logic [1:0] dst;
        logic [1:0] src;
        logic       wr;
        logic       halt;
        logic [3:0] pc_after;
        int         cnt;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] m_ram [16];
    logic [3:0] m_lptr;
    logic [7:0] m_imm;
    logic [2:0] alu_tab [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Walk the program as an ISA interpreter; cycle 1 is the first FETCH.
    task automatic build_model(input int halt_idx);
        int c;
        int pcv;
        c   = 1;
        pcv = 0;
        exp_q.delete();
        for (int k = 0; k < 1000; k++) begin
            ev_t        e;
            logic [7:0] b;
            b      = m_ram[pcv];
            pcv    = (pcv + 1) % 16;
            e.imm  = b[0];
            e.dst  = b[4:3];
            e.src  = b[2:1];
            e.halt = (b[7:5] == 3'd7);
            e.alu  = alu_tab[b[7:5]];
            e.add  = (b[7:5] != 3'd2);
            e.wr   = (b[7:5] < 3'd6);
            if (e.imm) begin
                m_imm = m_ram[pcv];
                pcv   = (pcv + 1) % 16;
                e.cyc = c + 4;
                c     = c + 5;
            end else begin
                e.cyc = c + 2;
                c     = c + 3;
            end
            e.immv     = m_imm;
            e.pc_after = 4'(pcv);
            e.cnt      = (k > 255) ? 255 : k;
            exp_q.push_back(e);
            if (e.halt || k == halt_idx) break;
        end
    endtask

    function automatic logic [45:0] all_outs();
        return {mem_bus.mem_cs, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
                alu_op, is_add, is_imm, imm_val, rf_we, rf_dst, rf_src2, pc, busy, done,
                instr_count};
    endfunction

    task automatic do_reset();
        run       = 1'b0;
        load_en   = 1'b0;
        halt_req  = 1'b0;
        load_data = 8'h00;
        RESET     = 1'b0;
        #1;
        chk("rst_async", 64'(all_outs()), 64'd0);
        tick();
        tick();
        RESET  = 1'b1;
        m_lptr = 4'd0;
        m_imm  = 8'h00;
        tick();
        chk("rst_idle", 64'(all_outs()), 64'd0);
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_en   = 1'b1;
        load_data = b;
        #1;
        chk("load_bus", 64'({mem_bus.mem_cs, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}),
            64'({1'b1, 1'b1, m_lptr, b}));
        @(posedge CLK);
        #1;
        load_en = 1'b0;
        m_ram[m_lptr] = b;
        m_lptr = m_lptr + 4'd1;
        chk("load_done_clr", 64'(done), 64'd0);
    endtask

    task automatic do_run(input int halt_idx, input bit poke_load, input string tag);
        int   cyc;
        int   bad_we;
        int   bad_rfwe;
        int   hexec;
        int   n;
        ev_t  last;
        bad_we   = 0;
        bad_rfwe = 0;
        build_model(halt_idx);
        n     = exp_q.size();
        last  = exp_q[n-1];
        hexec = (n == halt_idx + 1) ? last.cyc : -10;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (cyc = 1; cyc < 4000; cyc++) begin
            halt_req  = (cyc == hexec - 1) || (cyc == hexec);
            load_en   = poke_load && (cyc == 2);
            load_data = 8'h5A;
            if (!busy) break;
            if (mem_bus.mem_we) bad_we++;
            if (exp_q.size() > 0 && cyc == exp_q[0].cyc) begin
                ev_t e;
                e = exp_q.pop_front();
                chk({tag, "_exec"},
                    64'({rf_we, is_imm, rf_dst, (e.imm ? 2'b00 : rf_src2),
                         (e.halt ? 4'h0 : {alu_op, is_add}), imm_val, pc, instr_count}),
                    64'({e.wr, e.imm, e.dst, (e.imm ? 2'b00 : e.src),
                         (e.halt ? 4'h0 : {e.alu, e.add}), e.immv, e.pc_after, 8'(e.cnt)}));
            end else if (rf_we) begin
                bad_rfwe++;
            end
            tick();
        end
        halt_req = 1'b0;
        load_en  = 1'b0;
        chk({tag, "_ends_idle"}, 64'(busy), 64'd0);
        chk({tag, "_all_retired"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_no_we_busy"}, 64'(bad_we), 64'd0);
        chk({tag, "_no_stray_rfwe"}, 64'(bad_rfwe), 64'd0);
        chk({tag, "_final"}, 64'({done, instr_count, pc, rf_dst, imm_val}),
            64'({last.halt, 8'((n > 255) ? 255 : n), last.pc_after, last.dst, m_imm}));
    endtask

    initial begin
        int diff;
        RESET     = 1'b1;
        run       = 1'b0;
        load_en   = 1'b0;
        halt_req  = 1'b0;
        load_data = 8'h00;
        #3;
        do_reset();

        // Fill RAM with NOPs; the load pointer wraps back to 0.
        for (int i = 0; i < 16; i++) load_byte(8'hC0);

        // ADD r0,#5 ; HALT
        load_byte(8'h21);
        load_byte(8'h05);
        load_byte(8'hE0);
        do_run(99, 1'b0, "t1");
        chk("t1_done_cnt_pc", 64'({done, instr_count, pc}), 64'({1'b1, 8'd2, 4'd3}));
        load_byte(8'hC0);

        // SUB r1,r2 then stop on request
        do_reset();
        load_byte(8'h4C);
        do_run(0, 1'b0, "t2");
        chk("t2_decode", 64'({alu_op, is_add, is_imm, rf_dst, rf_src2}),
            64'({3'b001, 1'b0, 1'b0, 2'd1, 2'd2}));

        // 2-byte instruction at address 15 takes its immediate from address 0
        do_reset();
        load_byte(8'hAA);
        for (int i = 1; i < 15; i++) load_byte(8'hC0);
        load_byte(8'h29);
        do_run(15, 1'b0, "t3");
        chk("t3_wrap", 64'({pc, imm_val, is_imm}), 64'({4'd1, 8'hAA, 1'b1}));

        // halt_req during a NOP
        do_reset();
        load_byte(8'hC0);
        do_run(0, 1'b0, "t4");
        chk("t4_nop_halt", 64'({done, instr_count}), 64'({1'b0, 8'd1}));

        // run together with load_en: load wins
        load_en   = 1'b1;
        run       = 1'b1;
        load_data = 8'h3C;
        #1;
        chk("t5_load_wins_bus", 64'({mem_bus.mem_cs, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}),
            64'({1'b1, 1'b1, m_lptr, 8'h3C}));
        tick();
        load_en = 1'b0;
        run     = 1'b0;
        m_ram[m_lptr] = 8'h3C;
        m_lptr = m_lptr + 4'd1;
        chk("t5_stays_idle", 64'(busy), 64'd0);
        chk("t5_byte_written", 64'(ram[1]), 64'h3C);
        do_run(3, 1'b1, "t5");
        diff = 0;
        for (int i = 0; i < 16; i++) if (ram[i] !== m_ram[i]) diff++;
        chk("t5_ram_intact", 64'(diff), 64'd0);
        load_byte(8'hC0);

        // Reset during IFETCH, then during EXEC of a writing instruction
        do_reset();
        load_byte(8'h21);
        load_byte(8'h05);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        chk("t6_ifetch_cs", 64'({busy, mem_bus.mem_cs}), 64'({1'b1, 1'b1}));
        #2;
        RESET = 1'b0;
        #1;
        chk("t6_abort", 64'({busy, mem_bus.mem_cs, pc, rf_we}), 64'd0);
        tick();
        RESET  = 1'b1;
        m_lptr = 4'd0;
        m_imm  = 8'h00;
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_exec_we", 64'(rf_we), 64'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("t6_exec_abort", 64'({rf_we, mem_bus.mem_cs, busy}), 64'd0);
        tick();
        RESET = 1'b1;
        tick();

        // Random programs against the model
        do_reset();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) load_byte(8'($urandom));
            do_run(int'($urandom_range(0, 24)), it[0], "rnd");
        end

        // 256+ NOPs with no HALT: counter saturates
        do_reset();
        for (int i = 0; i < 16; i++) load_byte(8'hC0);
        do_run(259, 1'b0, "sat");
        chk("sat_count", 64'({done, instr_count}), 64'({1'b0, 8'd255}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
